// File: rtl/hdmi_clk_supervisor_pkg.sv
// Shared definitions for the HDMI clock supervisor: state encoding, widths and helpers.
package hdmi_clk_supervisor_pkg;

    localparam int HDMI_ST_W = 3;

    typedef enum logic [HDMI_ST_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_DIV_RST   = 3'd3,
        ST_SER_RST   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } hdmi_st_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hdmi_clk_supervisor_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module hdmi_clk_supervisor_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hdmi_clk_supervisor.sv
// Sequences HDMI rPLL reset, lock qualification and the CLKDIV / serializer reset release,
// with timeout retries, loss-of-lock recovery and a sticky fault state.
module hdmi_clk_supervisor
    import hdmi_clk_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 2700,
    parameter int LOCK_TIMEOUT       = 27000,
    parameter int DIV_RST_CYCLES     = 8,
    parameter int MAX_RETRY          = 3,
    parameter int CNT_W              = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_resetn,
    input  logic                 restart,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic                 clkdiv_resetn,
    output logic                 hdmi_resetn,
    output logic                 ready,
    output logic                 fault,
    output logic [HDMI_ST_W-1:0] state,
    output logic [7:0]           lol_count
);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] DIV_RST_LAST = CNT_W'(DIV_RST_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

    logic             lock_s;
    hdmi_st_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic [7:0]       lol_q, lol_d;
    logic             pll_reset_q, clkdiv_resetn_q, hdmi_resetn_q, ready_q, fault_q;

    hdmi_clk_supervisor_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_resetn),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        lol_d     = lol_q;
        retry_inc = retry_q + 2'd1;
        // restart wins over anything the current state would do, including a counted lock loss
        if (restart) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                    end
                end
                ST_STABLE: begin
                    // entry edge already saw lock high, so the window spans STABLE_DONE+1 edges
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_DONE) begin
                        state_d = ST_DIV_RST;
                        cnt_d   = '0;
                    end
                end
                ST_DIV_RST: begin
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == DIV_RST_LAST) begin
                        state_d = ST_SER_RST;
                        cnt_d   = '0;
                    end
                end
                ST_SER_RST: begin
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == DIV_RST_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        lol_d   = sat_inc8(lol_q);
                    end
                end
                ST_FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            retry_q         <= '0;
            lol_q           <= '0;
            pll_reset_q     <= 1'b1;
            clkdiv_resetn_q <= 1'b0;
            hdmi_resetn_q   <= 1'b0;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            lol_q           <= lol_d;
            pll_reset_q     <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
            clkdiv_resetn_q <= (state_d == ST_SER_RST) || (state_d == ST_RUN);
            hdmi_resetn_q   <= (state_d == ST_RUN);
            ready_q         <= (state_d == ST_RUN);
            fault_q         <= (state_d == ST_FAULT);
        end
    end

    assign pll_reset     = pll_reset_q;
    assign clkdiv_resetn = clkdiv_resetn_q;
    assign hdmi_resetn   = hdmi_resetn_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign lol_count     = lol_q;

endmodule

// File: tb/tb_hdmi_clk_supervisor.sv
// Randomized bench for hdmi_clk_supervisor against a phase/elapsed-time model of the sequencer.
module tb_hdmi_clk_supervisor;

    localparam int P_RST     = 4;
    localparam int P_STABLE  = 10;
    localparam int P_TIMEOUT = 50;
    localparam int P_DIV     = 3;
    localparam int P_RETRY   = 2;
    localparam int P_SYNC    = 2;

    localparam int S_PLL_RST = 0, S_WAIT = 1, S_STABLE = 2, S_DIV = 3,
                   S_SER = 4, S_RUN = 5, S_FAULT = 6;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, clkdiv_resetn, hdmi_resetn, ready, fault;
    logic [2:0] state;
    logic [7:0] lol_count;

    int compared = 0;
    int mismatched = 0;

    // model: current phase, edge at which it was entered, retry and loss-of-lock tallies
    int edge_cnt = 0;
    int m_state = S_PLL_RST;
    int m_entry = 0;
    int m_retry = 0;
    int m_lol = 0;
    int m_age = 0;
    bit m_lock_now = 1'b0;
    bit lock_hist[$];

    hdmi_clk_supervisor #(
        .SYNC_STAGES        (P_SYNC),
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STABLE),
        .LOCK_TIMEOUT       (P_TIMEOUT),
        .DIV_RST_CYCLES     (P_DIV),
        .MAX_RETRY          (P_RETRY),
        .CNT_W              (16)
    ) dut (
        .sys_clk       (clk),
        .sys_resetn    (rst_n),
        .restart       (restart),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .clkdiv_resetn (clkdiv_resetn),
        .hdmi_resetn   (hdmi_resetn),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .lol_count     (lol_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input int exp);
        compared++;
        if (act !== 8'(exp)) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic enter(input int s);
        m_state = s;
        m_entry = edge_cnt;
    endtask

    // reference model: the synced lock is the pll_lock sample from P_SYNC edges ago
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            edge_cnt = 0;
            m_state  = S_PLL_RST;
            m_entry  = 0;
            m_retry  = 0;
            m_lol    = 0;
            lock_hist.delete();
        end else begin
            edge_cnt++;
            m_lock_now = (lock_hist.size() == P_SYNC) ? lock_hist.pop_front() : 1'b0;
            lock_hist.push_back(pll_lock);
            m_age = edge_cnt - m_entry;
            if (restart) begin
                enter(S_PLL_RST);
                m_retry = 0;
            end else begin
                case (m_state)
                    S_PLL_RST: if (m_age == P_RST) enter(S_WAIT);
                    S_WAIT: begin
                        if (m_lock_now) enter(S_STABLE);
                        else if (m_age == P_TIMEOUT) begin
                            m_retry++;
                            enter((m_retry == P_RETRY) ? S_FAULT : S_PLL_RST);
                        end
                    end
                    S_STABLE: begin
                        if (!m_lock_now) enter(S_WAIT);
                        else if (m_age == P_STABLE + 1) enter(S_DIV);
                    end
                    S_DIV: begin
                        if (!m_lock_now) enter(S_PLL_RST);
                        else if (m_age == P_DIV) enter(S_SER);
                    end
                    S_SER: begin
                        if (!m_lock_now) enter(S_PLL_RST);
                        else if (m_age == P_DIV) begin
                            enter(S_RUN);
                            m_retry = 0;
                        end
                    end
                    S_RUN: begin
                        if (!m_lock_now) begin
                            enter(S_PLL_RST);
                            if (m_lol < 255) m_lol++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    initial forever begin
        logic e_pr, e_cd, e_run, e_f;
        @(negedge clk);
        if (rst_n) begin
            e_pr  = (m_state == S_PLL_RST) || (m_state == S_FAULT);
            e_cd  = (m_state == S_SER) || (m_state == S_RUN);
            e_run = (m_state == S_RUN);
            e_f   = (m_state == S_FAULT);
            compared++;
            if (state !== 3'(m_state) || pll_reset !== e_pr || clkdiv_resetn !== e_cd ||
                hdmi_resetn !== e_run || ready !== e_run || fault !== e_f ||
                lol_count !== 8'(m_lol)) begin
                mismatched++;
                $display("FAIL cycle edge %0d: got st=%0d pr=%b cd=%b hr=%b rdy=%b f=%b lol=%0d, expected st=%0d pr=%b cd=%b hr=%b rdy=%b f=%b lol=%0d",
                         edge_cnt, state, pll_reset, clkdiv_resetn, hdmi_resetn, ready, fault, lol_count,
                         m_state, e_pr, e_cd, e_run, e_run, e_f, m_lol);
            end
        end
    end

    task automatic at_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (m_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (m_state != s || state !== 3'(s)) begin
            mismatched++;
            $display("FAIL %s: got state %0d (model %0d), expected %0d within %0d cycles",
                     name, state, m_state, s, budget);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, r;
        repeat (3) @(negedge clk);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_clkdiv_resetn", clkdiv_resetn, 0);
        check("rst_hdmi_resetn", hdmi_resetn, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_state", state, S_PLL_RST);
        check("rst_lol", lol_count, 0);
        rst_n = 1'b1;

        // clean bring-up, lock sampled at edge 20
        at_edge(3);  check("up_pll_reset_e3", pll_reset, 1);
        at_edge(4);  check("up_pll_reset_e4", pll_reset, 0);
        at_edge(19); pll_lock = 1'b1;
        at_edge(35); check("up_clkdiv_e35", clkdiv_resetn, 0);
        at_edge(36); check("up_clkdiv_e36", clkdiv_resetn, 1);
        at_edge(38); check("up_ready_e38", ready, 0);
        at_edge(39); check("up_ready_e39", ready, 1);
        check("up_hdmi_e39", hdmi_resetn, 1);
        check("up_lol_e39", lol_count, 0);

        // first lock loss in RUN
        at_edge(45); e = edge_cnt; pll_lock = 1'b0;
        at_edge(e + 2); check("lol_ready_still_high", ready, 1);
        at_edge(e + 3);
        check("lol_ready_low", ready, 0);
        check("lol_hdmi_low", hdmi_resetn, 0);
        check("lol_clkdiv_low", clkdiv_resetn, 0);
        check("lol_count_1", lol_count, 1);
        pll_lock = 1'b1;
        wait_state(S_RUN, 100, "lol_relock");

        // one-cycle glitch during STABLE
        pulse_restart();
        wait_state(S_STABLE, 50, "glitch_reach_stable");
        repeat (4) @(negedge clk);
        e = edge_cnt; pll_lock = 1'b0;
        at_edge(e + 1); pll_lock = 1'b1;
        at_edge(e + 3);  check("glitch_wait_lock", state, S_WAIT);
        at_edge(e + 4);  check("glitch_restable", state, S_STABLE);
        at_edge(e + 20); check("glitch_ready_e20", ready, 0);
        at_edge(e + 21); check("glitch_ready_e21", ready, 1);

        // restart coinciding with a RUN lock loss is not counted
        e = edge_cnt; pll_lock = 1'b0;
        at_edge(e + 2); restart = 1'b1;
        at_edge(e + 3); restart = 1'b0;
        check("rs_loss_lol", lol_count, 1);
        check("rs_loss_state", state, S_PLL_RST);
        pll_lock = 1'b1;

        // no lock at all: two attempts then FAULT
        pll_lock = 1'b0;
        pulse_restart();
        r = edge_cnt;
        at_edge(r + 3);   check("nl_pr_r3", pll_reset, 1);
        at_edge(r + 4);   check("nl_pr_r4", pll_reset, 0);
        at_edge(r + 53);  check("nl_state_r53", state, S_WAIT);
        at_edge(r + 54);  check("nl_pr_r54", pll_reset, 1);
        at_edge(r + 57);  check("nl_pr_r57", pll_reset, 1);
        at_edge(r + 58);  check("nl_pr_r58", pll_reset, 0);
        at_edge(r + 107); check("nl_fault_r107", fault, 0);
        at_edge(r + 108);
        check("nl_state_r108", state, S_FAULT);
        check("nl_fault_r108", fault, 1);
        check("nl_pr_r108", pll_reset, 1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pll_lock = 1'($urandom_range(0, 1));
        end
        check("fault_held_state", state, S_FAULT);
        check("fault_held_flag", fault, 1);
        check("fault_held_pr", pll_reset, 1);

        // restart out of FAULT
        pll_lock = 1'b1;
        @(negedge clk);
        pulse_restart();
        check("fr_fault_clear", fault, 0);
        check("fr_state", state, S_PLL_RST);
        wait_state(S_RUN, 100, "fr_run");
        check("fr_lol_kept", lol_count, 1);

        // repeated lock losses saturate lol_count
        for (int i = 0; i < 299; i++) begin
            pll_lock = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            pll_lock = 1'b1;
            repeat (3) @(negedge clk);
            wait_state(S_RUN, 100, "sat_relock");
        end
        check("lol_saturated", lol_count, 255);

        // random lock activity with occasional restarts
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
            restart = ($urandom_range(0, 299) == 0);
        end
        restart = 1'b0;

        // async reset in DIV_RST with the clock stopped
        pll_lock = 1'b1;
        pulse_restart();
        wait_state(S_DIV, 100, "ar_reach_div");
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_pll_reset", pll_reset, 1);
        check("ar_clkdiv", clkdiv_resetn, 0);
        check("ar_hdmi", hdmi_resetn, 0);
        check("ar_ready", ready, 0);
        check("ar_fault", fault, 0);
        check("ar_state", state, S_PLL_RST);
        check("ar_lol", lol_count, 0);
        #10 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        at_edge(1); check("ar_post_state", state, S_PLL_RST);
        at_edge(4); check("ar_post_pr", pll_reset, 0);
        wait_state(S_RUN, 100, "ar_run");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
